framing_token_parser: RTL and testbench

FRAMING_TOKEN_PARSER -- requirements
Module: framing_token_parser

---
 rtl/framing_token_parser.sv | 118 +++++++++++
 tb/tb_framing_token_parser.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/framing_token_parser.sv
// framing_token_parser
//   Walks one 512-bit descrambled beat as 16 DW slots. It finds the
//   128b/130b framing tokens (IDL, SDP, STP) and tracks how many DWs of the
//   current packet are still to come, carrying that count across beats.
//   Every output is registered, so each mask lines up with the data_out
//   byte it describes, one pclk after the input.
// Ports
//   pclk, reset       clock, synchronous active-high reset
//   gen[2:0]          link generation; 3/4/5 enable parsing
//   data_in[511:0]    symbol bytes, byte k = data_in[8k+:8]
//   wr, wr_valid[63:0] beat valid and per-byte valid
//   data_out, wr_out, wr_valid_out   registered copies of the inputs
//   STP_out/SDP_out   start-token byte masks (bit 4j of slot j)
//   END_out           last byte of packet mask (bit 4j+3 of slot j)
//   framing_err       one pulse per beat containing any illegal token/length
module framing_token_parser (
  input  logic         pclk,
  input  logic         reset,
  input  logic [2:0]   gen,
  input  logic [511:0] data_in,
  input  logic         wr,
  input  logic [63:0]  wr_valid,
  output logic [511:0] data_out,
  output logic         wr_out,
  output logic [63:0]  wr_valid_out,
  output logic [63:0]  STP_out,
  output logic [63:0]  SDP_out,
  output logic [63:0]  END_out,
  output logic         framing_err
);

  localparam int SLOTS = 16;

  logic [10:0] rem;
  logic [10:0] rem_nxt;
  logic [10:0] r;
  logic [10:0] len;
  logic [7:0]  b0, b1;
  logic [63:0] stp_c, sdp_c, end_c;
  logic        err_c;
  logic        gen_ok;
  logic        parse;

  assign gen_ok = (gen == 3'b011) || (gen == 3'b100) || (gen == 3'b101);
  assign parse  = wr && gen_ok;

  // Slots are walked in order so the remaining-DW count ripples from one
  // slot to the next inside the same beat.
  always_comb begin
    r     = rem;
    len   = '0;
    b0    = '0;
    b1    = '0;
    stp_c = '0;
    sdp_c = '0;
    end_c = '0;
    err_c = 1'b0;
    if (parse) begin
      for (int j = 0; j < SLOTS; j++) begin
        b0  = data_in[32*j +: 8];
        b1  = data_in[32*j+8 +: 8];
        len = {b1[6:0], b0[7:4]};
        if (&wr_valid[4*j +: 4]) begin
          if (r != 11'd0) begin
            r = r - 11'd1;
            if (r == 11'd0) end_c[4*j+3] = 1'b1;
          end else if (b0 == 8'h00) begin
            // idle: nothing to mark
          end else if (b0 == 8'hF0 && b1 == 8'hAC) begin
            // DLLP is 8 bytes: token DW plus one more
            sdp_c[4*j] = 1'b1;
            r          = 11'd1;
          end else if (b0[3:0] == 4'hF) begin
            // length counts the STP DW itself, hence L-1 still to come;
            // the L>=5 guard keeps the subtraction from wrapping
            if (len >= 11'd5) begin
              stp_c[4*j] = 1'b1;
              r          = len - 11'd1;
            end else begin
              err_c = 1'b1;
            end
          end else begin
            err_c = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    if (!gen_ok)  rem_nxt = '0;
    else if (wr)  rem_nxt = r;
    else          rem_nxt = rem;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rem          <= '0;
      data_out     <= '0;
      wr_out       <= 1'b0;
      wr_valid_out <= '0;
      STP_out      <= '0;
      SDP_out      <= '0;
      END_out      <= '0;
      framing_err  <= 1'b0;
    end else begin
      rem          <= rem_nxt;
      data_out     <= data_in;
      wr_out       <= wr;
      wr_valid_out <= wr_valid;
      STP_out      <= stp_c;
      SDP_out      <= sdp_c;
      END_out      <= end_c;
      framing_err  <= err_c;
    end
  end

endmodule

// File: tb/tb_framing_token_parser.sv
module tb_framing_token_parser;

  logic         pclk = 1'b0;
  logic         reset;
  logic [2:0]   gen;
  logic [511:0] data_in;
  logic         wr;
  logic [63:0]  wr_valid;
  logic [511:0] data_out;
  logic         wr_out;
  logic [63:0]  wr_valid_out;
  logic [63:0]  STP_out, SDP_out, END_out;
  logic         framing_err;

  framing_token_parser dut (
    .pclk(pclk), .reset(reset), .gen(gen), .data_in(data_in), .wr(wr),
    .wr_valid(wr_valid), .data_out(data_out), .wr_out(wr_out),
    .wr_valid_out(wr_valid_out), .STP_out(STP_out), .SDP_out(SDP_out),
    .END_out(END_out), .framing_err(framing_err)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         rst;
    logic         w;
    logic [2:0]   g;
    logic [511:0] d;
    logic [63:0]  v;
    logic [63:0]  es, ep, ee;
    logic         eerr;
    string        nm;
  } vec_t;

  vec_t vt[$];

  // One slot of the generated random stream, with the marks it must produce.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
    logic        s, p, e, er;
  } slot_t;

  slot_t sq[$];

  task automatic step(input logic r, input logic w, input logic [2:0] g,
                      input logic [511:0] d, input logic [63:0] v,
                      input logic [63:0] es, input logic [63:0] ep,
                      input logic [63:0] ee, input logic eerr, input string nm);
    logic [511:0] xd;
    logic [63:0]  xv;
    logic         xw;
    reset = r; wr = w; gen = g; data_in = d; wr_valid = v;
    @(posedge pclk); #1;
    xd = r ? '0 : d;
    xv = r ? '0 : v;
    xw = r ? 1'b0 : w;
    n_tests++;
    if (STP_out !== es || SDP_out !== ep || END_out !== ee || framing_err !== eerr) begin
      n_fail++;
      $display("FAIL %s masks: got stp=%h sdp=%h end=%h err=%b, want stp=%h sdp=%h end=%h err=%b",
               nm, STP_out, SDP_out, END_out, framing_err, es, ep, ee, eerr);
    end
    n_tests++;
    if (data_out !== xd || wr_out !== xw || wr_valid_out !== xv) begin
      n_fail++;
      $display("FAIL %s copy: got wr=%b vld=%h data=%h, want wr=%b vld=%h data=%h",
               nm, wr_out, wr_valid_out, data_out, xw, xv, xd);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [2:0] g,
                     input logic [511:0] d, input logic [63:0] v,
                     input logic [63:0] es, input logic [63:0] ep,
                     input logic [63:0] ee, input logic eerr, input string nm);
    vec_t t;
    t.rst = r; t.w = w; t.g = g; t.d = d; t.v = v;
    t.es = es; t.ep = ep; t.ee = ee; t.eerr = eerr; t.nm = nm;
    vt.push_back(t);
  endtask

  function automatic logic [63:0] bit64(input int k);
    logic [63:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  // Push a slot, sometimes preceding it with a partially-valid slot that
  // the parser must skip without touching its count.
  task automatic push_slot(input logic [31:0] d, input logic s, input logic p,
                           input logic e, input logic er);
    slot_t t;
    if ($urandom_range(9) == 0) begin
      t.d = $urandom; t.v = 4'($urandom_range(14));
      t.s = 0; t.p = 0; t.e = 0; t.er = 0;
      sq.push_back(t);
    end
    t.d = d; t.v = 4'hF; t.s = s; t.p = p; t.e = e; t.er = er;
    sq.push_back(t);
  endtask

  task automatic gen_token();
    int          k;
    int          lmax;
    logic [10:0] l;
    logic [7:0]  b;
    logic [31:0] rr;
    k  = $urandom_range(9);
    rr = $urandom;
    case (k)
      0, 1: push_slot({rr[31:8], 8'h00}, 0, 0, 0, 0);
      2, 3: begin
        push_slot({rr[31:16], 8'hAC, 8'hF0}, 0, 1, 0, 0);
        push_slot($urandom, 0, 0, 1, 0);
      end
      4, 5, 6, 9: begin
        lmax = (k == 9) ? 300 : 48;
        l = 11'($urandom_range(lmax, 5));
        push_slot({rr[31:16], rr[15], l[10:4], l[3:0], 4'hF}, 1, 0, 0, 0);
        for (int i = 1; i < int'(l); i++)
          push_slot($urandom, 0, 0, (i == int'(l) - 1), 0);
      end
      7: begin
        l = 11'($urandom_range(4));
        push_slot({rr[31:16], rr[15], l[10:4], l[3:0], 4'hF}, 0, 0, 0, 1);
      end
      default: begin
        do b = 8'($urandom);
        while (b == 8'h00 || b[3:0] == 4'hF || b == 8'hF0);
        push_slot({rr[31:8], b}, 0, 0, 0, 1);
      end
    endcase
  endtask

  initial begin
    logic [511:0] d;
    logic [63:0]  m0, m1, m2;
    logic [63:0]  v;
    logic         er;
    logic [2:0]   g;
    slot_t        t;

    reset = 1'b1; wr = 1'b0; gen = 3'd0; data_in = '0; wr_valid = '0;

    // ---------------- directed vector table (applied in order) ----------
    d = {16{32'hDEADBEEF}};
    add(1, 1, 3, d, '1, '0, '0, '0, 0, "reset");
    d = '0; d[7:0] = 8'h6F;
    add(0, 1, 3, d, '1, bit64(0), '0, bit64(23), 0, "stp_l6");
    d = '0; d[71:64] = 8'hF0; d[79:72] = 8'hAC;
    add(0, 1, 4, d, '1, '0, bit64(8), bit64(15), 0, "sdp_slot2");
    d = '0; d[455:448] = 8'h0F; d[463:456] = 8'h01;
    add(0, 1, 5, d, '1, bit64(56), '0, '0, 0, "stp_l16_a");
    // L=16: STP slot and slot15 leave 14 DWs -> slots 0..13, last byte 55
    add(0, 1, 5, '0, '1, '0, '0, bit64(55), 0, "stp_l16_b");
    add(0, 1, 3, '0, '1, '0, '0, '0, 0, "idle_after");
    d = '0; d[7:0] = 8'h3F; d[39:32] = 8'hF0; d[47:40] = 8'hAC;
    add(0, 1, 3, d, '1, '0, bit64(4), bit64(11), 1, "stp_short");
    add(0, 1, 3, '0, '1, '0, '0, '0, 0, "err_pulse");
    d = '0; d[7:0] = 8'h8F; d[15:8] = 8'h02;
    add(0, 1, 3, d, '1, bit64(0), '0, '0, 0, "stp_l40");
    add(1, 1, 3, '0, '1, '0, '0, '0, 0, "rst_mid");
    d = '0; d[7:0] = 8'hF0; d[15:8] = 8'hAC;
    add(0, 1, 3, d, '1, '0, bit64(0), bit64(7), 0, "sdp_after_rst");
    d = '0; d[7:0] = 8'h6F;
    add(0, 1, 3'b010, d, '1, '0, '0, '0, 0, "gen2");
    d = '0; d[391:384] = 8'h6F;
    add(0, 1, 3, d, '1, bit64(48), '0, '0, 0, "hold_a");
    add(0, 0, 3, {16{32'hFFFFFFFF}}, '1, '0, '0, '0, 0, "hold_wr0");
    add(0, 1, 3, '0, '1, '0, '0, bit64(7), 0, "hold_b");
    d = '0; d[7:0] = 8'h5F; d[47:32] = 16'hFFFF; v = '1; v[7] = 1'b0;
    add(0, 1, 3, d, v, bit64(0), '0, bit64(23), 0, "skip_slot");
    d = '0; d[7:0] = 8'h11;
    add(0, 1, 3, d, '1, '0, '0, '0, 1, "bad_token");
    d = '0; d[487:480] = 8'hAF;
    add(0, 1, 3, d, '1, bit64(60), '0, '0, 0, "gen_clr_a");
    add(0, 1, 3'b110, '0, '1, '0, '0, '0, 0, "gen_clr_b");
    add(0, 1, 3, '0, '1, '0, '0, '0, 0, "gen_clr_c");
    d = '0; m0 = '0; m1 = '0;
    for (int j = 0; j < 16; j += 2) begin
      d[32*j +: 16] = 16'hACF0;
      m0[4*j] = 1'b1;
      m1[4*(j+1)+3] = 1'b1;
    end
    add(0, 1, 3, d, '1, '0, m0, m1, 0, "eight_ends");

    for (int i = 0; i < vt.size(); i++)
      step(vt[i].rst, vt[i].w, vt[i].g, vt[i].d, vt[i].v,
           vt[i].es, vt[i].ep, vt[i].ee, vt[i].eerr, vt[i].nm);

    // ---------------- random token stream vs constructed model ----------
    step(1, 0, 3, '0, '0, '0, '0, '0, 0, "rand_rst");
    while (sq.size() < 16 * 150) gen_token();
    while (sq.size() % 16 != 0) begin
      t.d = $urandom & 32'hFFFFFF00; t.v = 4'hF;
      t.s = 0; t.p = 0; t.e = 0; t.er = 0;
      sq.push_back(t);
    end
    while (sq.size() > 0) begin
      if ($urandom_range(9) == 0) begin
        for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
        v = {$urandom, $urandom};
        step(0, 0, 3, d, v, '0, '0, '0, 0, "rand_idle");
      end else begin
        m0 = '0; m1 = '0; m2 = '0; er = 1'b0;
        for (int j = 0; j < 16; j++) begin
          t = sq.pop_front();
          d[32*j +: 32] = t.d;
          v[4*j +: 4]   = t.v;
          m0[4*j]       = t.s;
          m1[4*j]       = t.p;
          m2[4*j+3]     = t.e;
          er            = er | t.er;
        end
        g = 3'($urandom_range(5, 3));
        step(0, 1, g, d, v, m0, m1, m2, er, "rand_beat");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
